// File: rtl/mult_seq_nxn_if.sv
// Request/result bundle for mult_seq_nxn: start/ready handshake, operands, and the done pulse with the held product.
// The master drives the request and operands. The slave (the multiplier) drives ready, done and product.
interface mult_seq_nxn_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               accum;
  logic [WIDTH-1:0]   dataa;
  logic [WIDTH-1:0]   datab;
  logic               ready;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, accum, dataa, datab,
    input  ready, done, product
  );

  modport slave (
    input  start, accum, dataa, datab,
    output ready, done, product
  );
endinterface

// File: rtl/mult_seq_nxn.sv
// Sequential NxN unsigned multiplier that adds one DIGITxDIGIT partial product per clock. MULT_SEQ_ACCUM_EN enables multiply-accumulate.
// Latency is D*D+1 cycles from acceptance to done. start is taken only while ready=1; requests arriving at other times are dropped, not queued.
module mult_seq_nxn #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic         clk,
  input  logic         reset_a,
  mult_seq_nxn_if.slave bus
);

  localparam int D  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int SW = $clog2(2 * WIDTH);

  if (DIGIT < 1) begin : g_bad_digit
    $error("mult_seq_nxn: DIGIT must be at least 1");
  end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
    $error("mult_seq_nxn: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        i_q, i_d;
  logic [IW-1:0]        j_q, j_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [DIGIT-1:0]     a_dig;
  logic [DIGIT-1:0]     b_dig;
  logic [2*DIGIT-1:0]   pp;
  logic [2*WIDTH-1:0]   pp_ext;
  logic [SW-1:0]        shamt;

`ifndef MULT_SEQ_ACCUM_EN
  logic unused_accum;
  assign unused_accum = bus.accum;
`endif

  // k is held as the digit pair (i, j) so that no divider is needed.
  always_comb begin
    a_dig  = DIGIT'(a_q >> (DIGIT * 32'(i_q)));
    b_dig  = DIGIT'(b_q >> (DIGIT * 32'(j_q)));
    pp     = {{DIGIT{1'b0}}, a_dig} * {{DIGIT{1'b0}}, b_dig};
    pp_ext = '0;
    pp_ext[2*DIGIT-1:0] = pp;
    shamt  = SW'(DIGIT * (32'(i_q) + 32'(j_q)));
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.dataa;
          b_d     = bus.datab;
          i_d     = '0;
          j_d     = '0;
`ifdef MULT_SEQ_ACCUM_EN
          prod_d  = bus.accum ? prod_q : '0;
`else
          prod_d  = '0;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        prod_d = prod_q + (pp_ext << shamt);
        if (j_q == IW'(D - 1)) begin
          j_d = '0;
          if (i_q == IW'(D - 1)) begin
            state_d = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.product = prod_q;

endmodule

// File: tb/tb_mult_seq_nxn.sv
// Self-checking bench for mult_seq_nxn (8x8, 2-bit digits): a cycle-level reference model checked every cycle, plus directed literal cases.
module tb_mult_seq_nxn;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int D     = WIDTH / DIGIT;
  localparam int NSTEP = D * D;

  logic clk     = 1'b0;
  logic reset_a = 1'b0;
  logic chk_en  = 1'b0;

  mult_seq_nxn_if #(.WIDTH(WIDTH)) bus ();

  mult_seq_nxn #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model. m_cnt counts cycles since acceptance (0 = idle, NSTEP+1 = done cycle).
  int          m_cnt  = 0;
  logic [15:0] m_prod = '0;
  logic [15:0] m_res  = '0;
  logic [15:0] m_base;

  always_comb begin
`ifdef MULT_SEQ_ACCUM_EN
    m_base = bus.accum ? m_prod : 16'h0000;
`else
    m_base = 16'h0000;
`endif
  end

  always @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      m_cnt  <= 0;
      m_prod <= '0;
      m_res  <= '0;
    end else if (m_cnt == 0) begin
      if (bus.start === 1'b1) begin
        m_cnt <= 1;
        m_res <= m_base + 16'(bus.dataa) * 16'(bus.datab);
      end
    end else if (m_cnt == NSTEP + 1) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == NSTEP) m_prod <= m_res;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(bus.ready), 32'(m_cnt == 0));
      chk("done", 32'(bus.done), 32'(m_cnt == NSTEP + 1));
      if (m_cnt == 0 || m_cnt == NSTEP + 1) chk("product", 32'(bus.product), 32'(m_prod));
    end
  end

  // Called at a negedge. It returns at the negedge of cycle 1 after the accepting edge.
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic acc);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.dataa = a;
    bus.datab = b;
    bus.accum = acc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dataa = 8'($urandom);
    bus.datab = 8'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op(input string name, input logic [7:0] a, input logic [7:0] b,
                    input logic acc, input logic [15:0] exp);
    int lat;
    accept(a, b, acc);
    wait_done(lat);
    chk({name, "_lat"}, 32'(lat), 32'(NSTEP + 1));
    chk(name, 32'(bus.product), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, ndone, t0, t1;
    logic [7:0]  acc_a   [6] = '{8'h03, 8'h05, 8'hFF, 8'h01, 8'h10, 8'hFF};
    logic [7:0]  acc_b   [6] = '{8'h04, 8'h06, 8'hFF, 8'hFE, 8'h10, 8'hFF};
    logic        acc_m   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef MULT_SEQ_ACCUM_EN
    logic [15:0] acc_exp [6] = '{16'd12, 16'd42, 16'hFE01, 16'hFEFF, 16'hFFFF, 16'hFE00};
`else
    logic [15:0] acc_exp [6] = '{16'd12, 16'd30, 16'hFE01, 16'h00FE, 16'h0100, 16'hFE01};
`endif

    bus.start = 1'b0;
    bus.accum = 1'b0;
    bus.dataa = '0;
    bus.datab = '0;
    #1 reset_a = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    reset_a = 1'b0;
    @(negedge clk);

    op("ff_x_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    op("12_x_34", 8'h12, 8'h34, 1'b0, 16'h03A8);

    // A start pulse during CALC must be dropped without side effects.
    accept(8'h00, 8'hAB, 1'b0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.dataa = 8'h77;
    bus.datab = 8'h99;
    chk("ign_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    chk("ign_lat", 32'(lat), 32'(NSTEP + 1 - 4));
    chk("ign_product", 32'(bus.product), 32'd0);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("ign_extra_done", 32'(ndone), 32'd0);

    // An asynchronous reset in mid-calculation takes effect without a clock edge.
    accept(8'd200, 8'd100, 1'b0);
    repeat (7) @(posedge clk);
    #3 reset_a = 1'b1;
    #1;
    chk("abort_product", 32'(bus.product), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_a = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    op("3_x_7", 8'd3, 8'd7, 1'b0, 16'd21);

    // With start held high, operations run back to back.
    bus.start = 1'b1;
    bus.accum = 1'b0;
    bus.dataa = 8'h12;
    bus.datab = 8'h34;
    wait_done(lat);
    t0 = cyc;
    @(negedge clk);
    wait_done(lat);
    t1 = cyc;
    chk("b2b_period", 32'(t1 - t0), 32'(NSTEP + 2));
    chk("b2b_product", 32'(bus.product), 32'h03A8);
    bus.start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) op($sformatf("accum_seq%0d", i), acc_a[i], acc_b[i], acc_m[i], acc_exp[i]);

    // Random traffic: stray starts, held starts, accumulate and occasional async resets.
    repeat (3000) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.dataa = 8'($urandom);
      bus.datab = 8'($urandom);
      bus.accum = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) begin
        #2 reset_a = 1'b1;
        #2 reset_a = 1'b0;
      end
    end
    bus.start = 1'b0;
    repeat (25) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
